// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-indexed data-memory port.
// Takes one request at a time over valid/ready, checks it for faults, and
// performs byte/halfword/word loads and stores. Sub-word stores are done as
// read-modify-write. Every request ends with a single-cycle response pulse.
module load_store_unit #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Access size encoding on req_size
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  // Word-index limit, sized to match addr[31:2]
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [1:0]  state_q,      state_d;
  logic        write_q,      write_d;
  logic [1:0]  size_q,       size_d;
  logic        unsigned_q,   unsigned_d;
  logic [1:0]  lane_q,       lane_d;       // byte offset within the word
  logic [15:0] wdata_q,      wdata_d;      // only the sub-word part is merged later
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  // Fault conditions evaluated on the live request at accept time.
  function automatic logic req_fault(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = addr[0];
      SIZE_WORD: bad = (addr[1:0] != 2'b00);
      SIZE_RSVD: bad = 1'b1;
      default:   bad = 1'b0;
    endcase
    if (addr[31:2] >= DEPTH_W) bad = 1'b1;
    return bad;
  endfunction

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = word[7:0];
    h   = word[15:0];
    res = word;
    case (size)
      SIZE_BYTE: begin
        case (lane)
          2'd0:    b = word[7:0];
          2'd1:    b = word[15:8];
          2'd2:    b = word[23:16];
          default: b = word[31:24];
        endcase
        res = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      end
      SIZE_HALF: begin
        h   = lane[1] ? word[31:16] : word[15:0];
        res = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of a memory word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [15:0] data);
    logic [31:0] res;
    res = word;
    case (size)
      SIZE_BYTE: begin
        case (lane)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          default: res[31:24] = data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (lane[1]) res[31:16] = data;
        else         res[15:0]  = data;
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Next-state and datapath decisions for the request FSM.
  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          lane_d     = req_addr[1:0];
          wdata_d    = req_wdata[15:0];
          mem_addr_d = {2'b00, req_addr[31:2]};
          if (req_fault(req_size, req_addr)) begin
            // Faults skip the memory entirely and respond next cycle.
            resp_rdata_d = 32'h0;
            resp_fault_d = 1'b1;
            state_d      = RESP;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            // Full-word stores need no read, so the write data is final now.
            mem_wdata_d = req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_wdata_d = merge_store(mem_rdata, size_q, lane_q, wdata_q);
          state_d     = WRITE;
        end else begin
          resp_rdata_d = load_extract(mem_rdata, size_q, lane_q, unsigned_q);
          resp_fault_d = 1'b0;
          state_d      = RESP;
        end
      end
      WRITE: begin
        resp_rdata_d = 32'h0;
        resp_fault_d = 1'b0;
        state_d      = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers; reset aborts any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values, as real flops do.
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Handshake and write strobe are decoded from state so reset drops them at once.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_we     = (state_q == WRITE);
    resp_rdata = resp_rdata_q;
    resp_fault = resp_fault_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized
// requests, checked against a behavioural reference model and a shadow memory.
module tb_load_store_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:DEPTH-1];  // memory the DUT actually talks to
  logic [31:0] ref_mem [0:DEPTH-1];  // expected memory contents

  int  n_compared   = 0;
  int  n_mismatched = 0;
  time t_accept     = 0;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[5:0]] : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    mem[idx]     = data;
    ref_mem[idx] = data;
  endtask

  // Issue one request (called at a negedge with the DUT idle), predict its
  // outcome from the access rules, and follow it to its response. With hold
  // set, req_valid stays high afterwards so the next call forms a burst.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    logic [31:0] idx, old, exp_rd, exp_new, v;
    logic        flt;
    int          exp_lat, exp_wr, sh, k, nwr;
    bit          seen, accepted;

    idx = addr >> 2;
    flt = (sz == 2'd3) || (sz == 2'd1 && addr[0]) ||
          (sz == 2'd2 && addr[1:0] != 2'b00) || (idx >= DEPTH);
    old     = flt ? 32'h0 : ref_mem[idx[5:0]];
    exp_rd  = 32'h0;
    exp_new = old;
    if (!flt && !wr) begin
      if (sz == 2'd0) begin
        sh = 8 * int'(addr[1:0]);
        v  = (old >> sh) & 32'hFF;
        if (!uns && v >= 32'd128) v = v - 32'd256;
        exp_rd = v;
      end else if (sz == 2'd1) begin
        sh = 16 * int'(addr[1]);
        v  = (old >> sh) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v - 32'd65536;
        exp_rd = v;
      end else begin
        exp_rd = old;
      end
    end
    if (!flt && wr) begin
      if (sz == 2'd0) begin
        sh      = 8 * int'(addr[1:0]);
        exp_new = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'd1) begin
        sh      = 16 * int'(addr[1]);
        exp_new = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end else begin
        exp_new = wd;
      end
    end
    exp_lat = flt ? 1 : ((wr && sz != 2'd2) ? 3 : 2);
    exp_wr  = (!flt && wr) ? 1 : 0;

    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;

    accepted = 0;
    for (int t = 0; t < 8; t++) begin
      if (req_ready) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    check("accept", 32'(accepted), 32'd1);
    if (!accepted) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t_accept = $time;
    @(negedge clk);
    if (!hold) begin
      // Scramble the request bus: the DUT must work from its latched copy.
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      req_valid    = 1'b0;
    end

    seen = 0;
    nwr  = 0;
    k    = 1;
    while (!seen && k <= 6) begin
      check("busy_ready", 32'(req_ready), 32'd0);
      if (mem_we) begin
        nwr++;
        check("wr_addr", mem_addr, idx);
        check("wr_data", mem_wdata, exp_new);
        if (mem_addr < DEPTH) mem[mem_addr[5:0]] = mem_wdata;
      end
      if (resp_valid) begin
        seen = 1;
        check("latency", 32'(k), 32'(exp_lat));
        check("resp_fault", 32'(resp_fault), 32'(flt));
        check("resp_rdata", resp_rdata, exp_rd);
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check("resp_seen", 32'(seen), 32'd1);
    check("n_writes", 32'(nwr), 32'(exp_wr));

    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_we", 32'(mem_we), 32'd0);
    if (!flt) begin
      ref_mem[idx[5:0]] = exp_new;
      check("mem_word", mem[idx[5:0]], exp_new);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t_prev;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);

    // Reset pulse asserted and released away from clock edges.
    #3 reset = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    #14 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_we", 32'(mem_we), 32'd0);
    check("post_rst_fault", 32'(resp_fault), 32'd0);
    check("post_rst_rdata", resp_rdata, 32'h0);
    check("post_rst_addr", mem_addr, 32'h0);
    check("post_rst_wdata", mem_wdata, 32'h0);

    // Word store.
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 0);

    // Byte and halfword loads from a known word.
    poke(2, 32'h80FF7F01);
    do_req(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'hA, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, 0);

    // Byte store as read-modify-write.
    poke(3, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 32'hD, 32'h000000AA, 0);

    // Faults: misaligned half, misaligned word, reserved size, out of range.
    do_req(1'b0, 2'd1, 1'b0, 32'h5,   32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h6,   32'h12345678, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h0,   32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);

    // Reset during the READ cycle of a byte store.
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr  = 32'hD; req_wdata = 32'h55; req_valid = 1'b1;
    check("mid_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #2 req_valid = 1'b0;
    check("mid_read_ready", 32'(req_ready), 32'd0);
    check("mid_read_we", 32'(mem_we), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_rst_resp", 32'(resp_valid), 32'd0);
      check("after_rst_we", 32'(mem_we), 32'd0);
      check("after_rst_ready", 32'(req_ready), 32'd1);
    end
    check("after_rst_mem", mem[3], ref_mem[3]);

    // Three loads with req_valid held high throughout.
    do_req(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 1);
    t_prev = t_accept;
    do_req(1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 1);
    check("b2b_spacing1", 32'((t_accept - t_prev) / 10), 32'd3);
    t_prev = t_accept;
    do_req(1'b0, 2'd1, 1'b0, 32'h1E, 32'h0, 1);
    check("b2b_spacing2", 32'((t_accept - t_prev) / 10), 32'd3);
    req_valid = 1'b0;

    // Randomized mix of loads, stores and faults.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 15);
      sz = (r == 15) ? 2'd3 : 2'(r % 3);
      a  = 32'($urandom_range(0, DEPTH * 4 + 31));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 31) == 0) a = $urandom;
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 0);
    end

    for (int i = 0; i < DEPTH; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the datapath over a valid/ready handshake and drives the word-indexed data memory port (write enable, address, write data, combinational read data).
- Adds byte and halfword access: lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores.
- Checks alignment, size and range before any memory access, and returns a one-cycle response pulse.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached memory; a word index >= DEPTH is a range fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid: misaligned, reserved size or out of range.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word index = {2'b00, addr[31:2]}.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data for mem_addr.

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE.
  - req_ready=1; resp_valid, resp_fault, mem_we = 0; resp_rdata, mem_addr, mem_wdata, all latched fields = 0.
  - Reset asserted mid-operation aborts it with no write. mem_we falls immediately because it is decoded from state.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clk edge, latch write, size, unsigned, addr, wdata; mem_addr takes the latched word index.
  - Fault check at accept: size=3; size=1 with addr[0]=1; size=2 with addr[1:0]!=0; addr[31:2] >= DEPTH.
  - Fault -> RESP with resp_fault=1; no memory access.
  - Load -> READ. Word store -> WRITE. Byte or halfword store -> READ.
- READ:
  - Exactly one cycle; mem_we=0.
  - At the edge, capture mem_rdata into an internal word register.
  - Load -> RESP, with resp_rdata = selected lane, extended:
    - byte lane = addr[1:0] (little-endian, lane 0 = bits 7:0);
    - halfword lane = addr[1] (0 = bits 15:0).
  - Store -> WRITE.
- WRITE:
  - Exactly one cycle; mem_we=1.
  - mem_wdata is the captured word with the addressed lane replaced by req_wdata[7:0] or [15:0].
  - Word store writes req_wdata unmodified.
  - Next state is RESP.
- RESP:
  - resp_valid=1 for one cycle; resp_fault as determined at accept; req_ready=0.
  - Next state is IDLE.
  - resp_valid is not back-pressured; the consumer must take it.
- Latency, counted in clocks from the accept edge to the resp_valid cycle:
  - load 2;
  - word store 2;
  - sub-word store 3;
  - fault 1.
- Throughput: the next request is accepted no earlier than the edge ending the RESP cycle. No overlap and no request queuing.
- Output registers:
  - resp_rdata and resp_fault are registered and held until the next response, but are valid only when resp_valid=1.
  - mem_wdata is registered and held outside WRITE.
- Changes to req_* after acceptance have no effect.
- mem_we is never asserted in IDLE, READ or RESP, or in any cycle of a faulted request.

Test Plan:
- Reset then word store:
  - Stimulus: reset pulse mid-cycle; then store word 0xDEADBEEF at addr 0x8.
  - Required: after reset, req_ready=1 and mem_we=0. mem_we=1 for one cycle with mem_addr=2 and mem_wdata=0xDEADBEEF. resp_valid 2 clocks after accept, resp_fault=0.
- Signed and unsigned byte loads:
  - Setup: mem[2]=0x80FF7F01.
  - Signed byte load, addr 0xB -> resp_rdata=0xFFFFFF80.
  - Unsigned byte load, addr 0xA -> 0x000000FF.
  - Signed halfword load, addr 0x8 -> 0x00007F01.
  - All responses arrive 2 clocks after accept.
- Byte store read-modify-write:
  - Setup: mem[3]=0x11223344.
  - Stimulus: store byte 0xAA at addr 0xD.
  - Required: READ cycle with mem_we=0, then WRITE cycle with mem_wdata=0x1122AA44 at mem_addr=3. resp_valid 3 clocks after accept.
- Faults:
  - Halfword load at addr 0x5, word store at 0x6, size=3 at 0x0, word load at 0x100 (index 64, DEPTH=64).
  - Required for each: resp_valid 1 clock after accept, resp_fault=1, resp_rdata=0, mem_we never asserted.
- Reset mid-operation:
  - Stimulus: byte store accepted, reset asserted during READ.
  - Required: mem_we never asserted, memory unchanged, resp_valid=0, state IDLE, req_ready=1.
- Back-to-back requests:
  - Stimulus: req_valid held high with three queued loads.
  - Required: req_ready low from accept through RESP. Accepts spaced exactly 3 clocks apart; responses in order with correct data.
